uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Round-robin scheduler that shares the single UART transmitter among NUM_REQ independent byte producers.
- Accepts one byte per grant from the winning requester and drives the transmitter's start/data inputs.
- Holds start until the transmitter reports busy, then waits for the frame to complete before the next grant.
- Sits between client logic and the transmitter inside the UART top level. Runs on the system clock; the transmitter may advance only on baud ticks, so the start strobe is a level held until busy is observed.

Parameters:
- NUM_REQ, 4, number of requesters (2..8); GW = clog2(NUM_REQ).
- DATA_W, 8, byte width passed to the transmitter.
- TIMEOUT_CYC, 65535, clk cycles allowed between tx_start assertion and tx_busy rising; counter width = clog2(TIMEOUT_CYC+1).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-requester request level; requester holds req and its data stable until it sees ack.
- req_data  input  NUM_REQ*DATA_W  packed bytes; requester i occupies bits [i*DATA_W +: DATA_W].
- ack  output  NUM_REQ  one-hot, one-cycle pulse: byte from that requester accepted.
- tx_start  output  1  start request to transmitter, level-held.
- tx_data  output  DATA_W  byte presented to transmitter, stable from START entry until return to IDLE.
- tx_busy  input  1  transmitter shifting a frame (start bit through stop bit).
- grant_id  output  GW  index of current/last granted requester.
- active  output  1  high in any state other than IDLE.
- timeout_err  output  1  sticky: transmitter never acknowledged a start.
- clr_err  input  1  clears timeout_err.

Behaviour:
- Reset (sync, rst=1 at edge), effective at that edge:
  - state=IDLE; ack=0; tx_start=0; tx_data=0; active=0; timeout_err=0; counter=0.
  - grant_id=NUM_REQ-1, so requester 0 has first priority.
  - Reset during START or WAIT_DONE abandons the byte; tx_start drops at that edge.
- FSM states are IDLE, START and WAIT_DONE.
- IDLE:
  - Transition condition: |req && !tx_busy.
  - Winner = first i with req[i]=1, searching (grant_id+1) mod NUM_REQ upward with wrap.
  - On that edge, registered: tx_data <= winner's slice; grant_id <= winner; ack <= onehot(winner); tx_start <= 1; counter <= 0; state <= START.
  - If tx_busy=1 in IDLE (foreign/stale frame), no grant is made.
- START:
  - tx_start=1 and ack is high only in the first START cycle. req is ignored.
  - tx_busy=1 at edge: tx_start <= 0; state <= WAIT_DONE.
  - Otherwise, when counter == TIMEOUT_CYC-1: timeout_err <= 1; tx_start <= 0; state <= IDLE. The byte is dropped; it was already acked.
  - Otherwise counter increments.
- WAIT_DONE:
  - Wait for tx_busy=0, then state <= IDLE.
  - The next grant therefore occurs at the earliest one cycle after busy falls (one idle cycle minimum between frames).
- Round-robin fairness: the most recently granted requester has lowest priority next arbitration. A requester holding req continuously is served at most once per NUM_REQ grants while others request.
- active = (state != IDLE), registered with state.
- timeout_err: set has priority over clr_err in the same cycle. Otherwise clr_err=1 clears it. Only rst and clr_err clear it.
- A req rising during START or WAIT_DONE is held by the requester and considered at the next IDLE.
- No combinational path from req or tx_busy to any output.

Test Plan:
- Single byte: req[2]=1, data2=0xA5, tx_busy rises 3 cycles after tx_start and falls 40 cycles later.
  - Expect ack=0100 for one cycle, tx_data=0xA5, tx_start high exactly 3 cycles, grant_id=2.
  - Expect active low one cycle after busy falls.
- Round-robin: req=1111 held continuously with distinct bytes 0x10..0x13 and model transmitter.
  - Grant order 0,1,2,3,0,1; each ack precedes its tx_data; never two grants without an intervening busy pulse.
- Priority wrap: after a grant to 3, assert req=1001 simultaneously.
  - Requester 0 granted before 3.
- Timeout: TIMEOUT_CYC=16, tx_busy tied 0, req[1]=1.
  - Expect tx_start high 16 cycles, then timeout_err=1 and state IDLE.
  - clr_err with no new timeout clears it; clr_err in the same cycle as a new timeout leaves it 1.
- Reset mid-frame: rst asserted in WAIT_DONE while tx_busy=1.
  - At the next edge, tx_start=0, active=0, grant_id=NUM_REQ-1.
  - After rst release with tx_busy still 1, no grant until busy falls.
- Busy at idle: tx_busy=1 with req=0010.
  - No ack until tx_busy=0, then grant follows on the next edge.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// ---------------------------------------------------------------------------
// Round-robin scheduler that lets NUM_REQ byte producers share one UART
// transmitter. One byte is taken per grant. tx_start stays high until the
// transmitter reports busy. The next grant waits until that frame has
// finished.
//
// Handshake semantics (client side and transmitter side):
//   * A client raises req[i] and holds req[i] and its byte in
//     req_data[i*DATA_W +: DATA_W] stable until it sees ack[i]. ack[i] is a
//     one-cycle pulse meaning "byte captured"; the client may then drop or
//     re-raise req[i] freely.
//   * Toward the transmitter, tx_start is a level held with tx_data stable
//     until tx_busy is observed high. After that the arbiter waits for
//     tx_busy to fall before it returns to IDLE.
//
// Ports:
//   clk, rst     system clock; synchronous active-high reset
//   req          per-requester request levels
//   req_data     packed request bytes, requester i at [i*DATA_W +: DATA_W]
//   ack          one-hot acceptance pulse
//   tx_start     start level to the transmitter
//   tx_data      byte presented to the transmitter
//   tx_busy      transmitter is shifting a frame
//   grant_id     index of the current or last granted requester
//   active       high whenever the FSM is not in IDLE
//   timeout_err  sticky: a start was never acknowledged by busy
//   clr_err      clears timeout_err (a new timeout wins)
//   dbg_state    current FSM state encoding (0 IDLE, 1 START, 2 WAIT_DONE)
//
// All outputs are registered, so there is no combinational path from req or
// tx_busy to any output.
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 65535,
    localparam int GW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int CW         = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          ack,
    output logic                        tx_start,
    output logic [DATA_W-1:0]           tx_data,
    input  logic                        tx_busy,
    output logic [GW-1:0]               grant_id,
    output logic                        active,
    output logic                        timeout_err,
    input  logic                        clr_err,
    output logic [1:0]                  dbg_state
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [CW-1:0]       cnt, cnt_nxt;
    logic [NUM_REQ-1:0]  ack_nxt;
    logic                tx_start_nxt;
    logic [DATA_W-1:0]   tx_data_nxt;
    logic [GW-1:0]       grant_id_nxt;
    logic                timeout_err_nxt;
    logic [GW-1:0]       win_idx;

    // Search starts just past the last grant and wraps, so the last winner
    // has the lowest priority. The sum needs one extra bit before the wrap.
    function automatic logic [GW-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                              input logic [GW-1:0]      last);
        logic [GW-1:0] pick;
        logic          found;
        logic [GW:0]   sum;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            sum = {1'b0, last} + (GW+1)'(k);
            if (sum >= (GW+1)'(NUM_REQ)) begin
                sum = sum - (GW+1)'(NUM_REQ);
            end
            if (!found && r[sum[GW-1:0]]) begin
                pick  = sum[GW-1:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign win_idx = rr_pick(req, grant_id);

    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        ack_nxt         = '0;
        tx_start_nxt    = tx_start;
        tx_data_nxt     = tx_data;
        grant_id_nxt    = grant_id;
        // A timeout set below overrides this clear.
        timeout_err_nxt = clr_err ? 1'b0 : timeout_err;

        case (state)
            IDLE: begin
                // A busy transmitter in IDLE is a foreign or stale frame.
                // Do not grant until it ends.
                if (|req && !tx_busy) begin
                    tx_data_nxt      = req_data[win_idx*DATA_W +: DATA_W];
                    grant_id_nxt     = win_idx;
                    ack_nxt[win_idx] = 1'b1;
                    tx_start_nxt     = 1'b1;
                    cnt_nxt          = '0;
                    state_nxt        = START;
                end
            end
            START: begin
                if (tx_busy) begin
                    tx_start_nxt = 1'b0;
                    state_nxt    = WAIT_DONE;
                end else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
                    // The byte was already acked, so it is lost here.
                    timeout_err_nxt = 1'b1;
                    tx_start_nxt    = 1'b0;
                    state_nxt       = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                tx_start_nxt = 1'b0;
                state_nxt    = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            ack         <= '0;
            tx_start    <= 1'b0;
            tx_data     <= '0;
            grant_id    <= GW'(NUM_REQ - 1);
            active      <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            ack         <= ack_nxt;
            tx_start    <= tx_start_nxt;
            tx_data     <= tx_data_nxt;
            grant_id    <= grant_id_nxt;
            active      <= (state_nxt != IDLE);
            timeout_err <= timeout_err_nxt;
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter (NUM_REQ=4, DATA_W=8, TIMEOUT_CYC=16).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ     = 4;
    localparam int DATA_W      = 8;
    localparam int TIMEOUT_CYC = 16;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic [1:0]  grant_id;
    logic        active;
    logic        timeout_err;
    logic        clr_err;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .DATA_W     (DATA_W),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_data   (req_data),
        .ack        (ack),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_busy    (tx_busy),
        .grant_id   (grant_id),
        .active     (active),
        .timeout_err(timeout_err),
        .clr_err    (clr_err),
        .dbg_state  (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int         n_checks;
    int         n_fail;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        int          gid;
        logic [7:0]  byte_exp;
        int          start_cyc;
        int          busy_cyc;
        bit          drop;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Advance to the next falling edge, then wait (bounded) for an ack.
    task automatic wait_ack();
        int waitc;
        waitc = 0;
        @(negedge clk);
        while (ack === 4'b0 && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        check("ack_arrives", 32'(waitc < 50), 32'd1);
    endtask

    // One complete frame with a model transmitter: busy rises after
    // start_cyc cycles of tx_start and stays high busy_cyc cycles.
    task automatic run_frame(input vec_t v);
        int         sc;
        logic [7:0] exp_b;
        wait_ack();
        check("ack_onehot", 32'(ack), 32'd1 << v.gid);
        check("grant_id", 32'(grant_id), 32'(v.gid));
        check("tx_data_at_grant", 32'(tx_data), 32'(v.byte_exp));
        check("tx_start_rise", 32'(tx_start), 32'd1);
        check("active_rise", 32'(active), 32'd1);
        if (v.drop) req[v.gid] = 1'b0;
        sc = 1;
        while (sc < v.start_cyc) begin
            @(negedge clk);
            check("tx_start_held", 32'(tx_start), 32'd1);
            check("ack_single_pulse", 32'(ack), 32'd0);
            sc++;
        end
        tx_busy = 1'b1;
        @(negedge clk);
        check("tx_start_drop", 32'(tx_start), 32'd0);
        exp_b = exp_q.pop_front();
        check("sb_byte", 32'(tx_data), 32'(exp_b));
        for (int i = 1; i < v.busy_cyc; i++) begin
            @(negedge clk);
        end
        check("wait_active", 32'(active), 32'd1);
        check("wait_no_ack", 32'(ack), 32'd0);
        check("tx_data_stable", 32'(tx_data), 32'(v.byte_exp));
        tx_busy = 1'b0;
        @(negedge clk);
        check("idle_after_busy", 32'(active), 32'd0);
        check("idle_gap_no_ack", 32'(ack), 32'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        int n;
        int bad;
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        req      = '0;
        req_data = '0;
        tx_busy  = 1'b0;
        clr_err  = 1'b0;

        //          req    data           gid byte  start busy drop
        vecs[0] = '{4'hF, 32'h13121110, 0, 8'h10, 1,  5, 1'b0};
        vecs[1] = '{4'hF, 32'h13121110, 1, 8'h11, 2,  6, 1'b0};
        vecs[2] = '{4'hF, 32'h13121110, 2, 8'h12, 1,  7, 1'b0};
        vecs[3] = '{4'hF, 32'h13121110, 3, 8'h13, 3,  8, 1'b0};
        vecs[4] = '{4'hF, 32'h13121110, 0, 8'h10, 2,  9, 1'b0};
        vecs[5] = '{4'hF, 32'h13121110, 1, 8'h11, 1, 10, 1'b0};
        vecs[6] = '{4'h4, 32'h00A50000, 2, 8'hA5, 3, 40, 1'b1};
        vecs[7] = '{4'h8, 32'h5A000000, 3, 8'h5A, 2,  4, 1'b1};
        vecs[8] = '{4'h9, 32'h77000033, 0, 8'h33, 1,  3, 1'b1};
        vecs[9] = '{4'h8, 32'h77000033, 3, 8'h77, 2,  3, 1'b1};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_active", 32'(active), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd3);
        check("rst_state", 32'(dbg_state), 32'd0);
        rst = 1'b0;

        // Table: round-robin, single byte, priority wrap
        for (int i = 0; i < 10; i++) begin
            req      = vecs[i].req;
            req_data = vecs[i].data;
            exp_q.push_back(vecs[i].byte_exp);
            run_frame(vecs[i]);
        end
        check("sb_queue_empty", 32'(exp_q.size()), 32'd0);

        // Timeout: tx_busy never rises
        req      = 4'b0010;
        req_data = 32'h0000C300;
        wait_ack();
        check("to_ack", 32'(ack), 32'b0010);
        check("to_grant_id", 32'(grant_id), 32'd1);
        check("to_tx_data", 32'(tx_data), 32'hC3);
        req = 4'b0000;
        n = 1;
        while (n < 100) begin
            @(negedge clk);
            if (!tx_start) break;
            n++;
        end
        check("to_start_len", 32'(n), 32'd16);
        check("to_err_set", 32'(timeout_err), 32'd1);
        check("to_idle_active", 32'(active), 32'd0);
        check("to_idle_state", 32'(dbg_state), 32'd0);
        @(negedge clk);
        check("to_err_sticky", 32'(timeout_err), 32'd1);
        clr_err = 1'b1;
        @(negedge clk);
        check("to_err_cleared", 32'(timeout_err), 32'd0);
        clr_err = 1'b0;

        // Second timeout with clr_err on the same edge: the set wins
        req = 4'b0010;
        wait_ack();
        check("to2_grant_id", 32'(grant_id), 32'd1);
        req = 4'b0000;
        n = 1;
        while (n < 16) begin
            @(negedge clk);
            n++;
        end
        check("to2_pre_edge_start", 32'(tx_start), 32'd1);
        check("to2_pre_edge_err", 32'(timeout_err), 32'd0);
        clr_err = 1'b1;
        @(negedge clk);
        check("to2_set_beats_clr", 32'(timeout_err), 32'd1);
        check("to2_start_drop", 32'(tx_start), 32'd0);
        clr_err = 1'b0;
        @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        check("to2_err_cleared", 32'(timeout_err), 32'd0);
        clr_err = 1'b0;

        // Reset mid-frame while busy, then busy at idle
        req      = 4'b0100;
        req_data = 32'h005E6B00;
        wait_ack();
        check("rm_grant_id", 32'(grant_id), 32'd2);
        req     = 4'b0000;
        tx_busy = 1'b1;
        @(negedge clk);
        check("rm_wait_state", 32'(dbg_state), 32'd2);
        rst = 1'b1;
        @(negedge clk);
        check("rm_tx_start", 32'(tx_start), 32'd0);
        check("rm_active", 32'(active), 32'd0);
        check("rm_grant_id_rst", 32'(grant_id), 32'd3);
        check("rm_tx_data", 32'(tx_data), 32'd0);
        rst = 1'b0;
        req = 4'b0010;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (ack !== 4'b0 || active !== 1'b0) bad++;
        end
        check("busy_idle_no_grant", 32'(bad), 32'd0);
        tx_busy = 1'b0;
        @(negedge clk);
        check("busy_idle_ack", 32'(ack), 32'b0010);
        check("busy_idle_grant_id", 32'(grant_id), 32'd1);
        check("busy_idle_tx_data", 32'(tx_data), 32'h6B);
        req     = 4'b0000;
        tx_busy = 1'b1;
        @(negedge clk);
        tx_busy = 1'b0;
        @(negedge clk);
        check("busy_idle_done", 32'(active), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
